// File: rtl/vote_sequencer.sv
// ---------------------------------------------------------------------------
// vote_sequencer
//   Ballot controller sitting between the debounced candidate buttons and the
//   vote counters / LED mode logic. One ballot is armed per poll-officer
//   enable; exactly one confirmed single-button press is accepted, producing
//   a one-cycle one-hot cand_inc pulse followed by a held vote_casted
//   acknowledge. Ballots are refused in display mode and once the ballot
//   counter has saturated.
//
//   Optional feature macro: VOTE_TIMEOUT_EN
//     defined   : an ARMED state idle timer returns to IDLE after
//                 TIMEOUT_CYCLES button-free cycles, pulsing timeout.
//     undefined : ARMED waits indefinitely; timeout is tied to 0.
//
//   Ports
//     clk            in   system clock, rising edge
//     rst            in   asynchronous, active-low reset
//     mode           in   0 = voting, 1 = display
//     ballot_enable  in   poll-officer arm request (level, sampled in IDLE)
//     btn[3:0]       in   debounced buttons, bit i = candidate i+1
//     cand_inc[3:0]  out  one-hot one-cycle increment (CAST state only)
//     vote_casted    out  high for HOLD_CYCLES cycles after a cast
//     armed          out  high in ARMED and CONFIRM
//     multi_press    out  high while armed with more than one button set
//     full           out  ballot_count is all ones
//     ballot_count   out  saturating count of ballots cast
//     timeout        out  one-cycle pulse on ARMED expiry
//     state_dbg[2:0] out  current FSM state, for debug/checkers
//
//   Protocol: ballot_enable is a level request acted on only in IDLE; the
//   completion of a ballot is signalled by cand_inc (one cycle) and then
//   vote_casted (HOLD_CYCLES cycles). There is no back-pressure: the counters
//   downstream must accept cand_inc in the cycle it is high.
// ---------------------------------------------------------------------------
module vote_sequencer #(
  parameter int CONFIRM_CYCLES = 4,
  parameter int HOLD_CYCLES    = 8,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic             ballot_enable,
  input  logic [3:0]       btn,
  output logic [3:0]       cand_inc,
  output logic             vote_casted,
  output logic             armed,
  output logic             multi_press,
  output logic             full,
  output logic [CNT_W-1:0] ballot_count,
  output logic             timeout,
  output logic [2:0]       state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARMED   = 3'd1,
    S_CONFIRM = 3'd2,
    S_CAST    = 3'd3,
    S_ACK     = 3'd4,
    S_RELEASE = 3'd5
  } state_t;

  localparam int CONF_W = $clog2(CONFIRM_CYCLES + 1);
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

  state_t            state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [CONF_W-1:0] conf_q, conf_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [3:0]        idx_mask;
  logic [1:0]        btn_idx;
  logic              one_btn;
  logic              many_btn;
  logic              expire;

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  assign one_btn  = (btn != 4'b0000) && ((btn & (btn - 4'd1)) == 4'b0000);
  assign many_btn = (btn != 4'b0000) && !one_btn;
  assign idx_mask = 4'b0001 << idx_q;

  always_comb begin
    btn_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (btn[i]) btn_idx = 2'(i);
    end
  end

`ifdef VOTE_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_q, to_d;

  // Counts button-free cycles while ARMED; any button activity or leaving
  // ARMED restarts it.
  assign expire = (state_q == S_ARMED) && (btn == 4'b0000) &&
                  (to_q == TO_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    to_d = '0;
    if ((state_q == S_ARMED) && (btn == 4'b0000) && !expire) to_d = to_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_q    <= '0;
      timeout <= 1'b0;
    end else begin
      to_q    <= to_d;
      timeout <= expire;
    end
  end
`else
  assign expire  = 1'b0;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    conf_d  = conf_q;
    hold_d  = hold_q;
    case (state_q)
      S_IDLE: begin
        if (ballot_enable && !mode && !full) state_d = S_ARMED;
      end
      S_ARMED: begin
        conf_d = '0;
        if (expire) begin
          state_d = S_IDLE;
        end else if (!mode && one_btn) begin
          state_d = S_CONFIRM;
          idx_d   = btn_idx;
        end
      end
      S_CONFIRM: begin
        // The last of CONFIRM_CYCLES qualifying cycles moves on to CAST.
        if (!mode && (btn == idx_mask)) begin
          if (conf_q == CONF_W'(CONFIRM_CYCLES - 1)) begin
            state_d = S_CAST;
            conf_d  = '0;
          end else begin
            conf_d = conf_q + 1'b1;
          end
        end else begin
          state_d = S_ARMED;
          conf_d  = '0;
        end
      end
      S_CAST: begin
        state_d = S_ACK;
        hold_d  = '0;
      end
      S_ACK: begin
        if (hold_q == HOLD_W'(HOLD_CYCLES - 1)) begin
          state_d = S_RELEASE;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      S_RELEASE: begin
        // A button still held from the cast must be released before re-arming.
        if (btn == 4'b0000) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      idx_q        <= 2'd0;
      conf_q       <= '0;
      hold_q       <= '0;
      ballot_count <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      conf_q  <= conf_d;
      hold_q  <= hold_d;
      if ((state_q == S_CAST) && !full) ballot_count <= ballot_count + 1'b1;
    end
  end

  // Outputs decode directly from the state register, so an asynchronous
  // reset clears them immediately.
  assign full        = &ballot_count;
  assign armed       = (state_q == S_ARMED) || (state_q == S_CONFIRM);
  assign multi_press = armed && many_btn;
  assign cand_inc    = (state_q == S_CAST) ? idx_mask : 4'b0000;
  assign vote_casted = (state_q == S_ACK);
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_vote_sequencer.sv
module tb_vote_sequencer;

  localparam int CONF = 4;
  localparam int HOLD = 8;
  localparam int TMO  = 16;
  localparam int CW   = 8;

  // ---------------- clock / reset / signals ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          mode = 1'b0;
  logic          ballot_enable = 1'b0;
  logic [3:0]    btn = 4'b0000;
  logic [3:0]    cand_inc;
  logic          vote_casted;
  logic          armed;
  logic          multi_press;
  logic          full;
  logic [CW-1:0] ballot_count;
  logic          timeout;
  logic [2:0]    state_dbg;

  always #5 clk = ~clk;

  vote_sequencer #(
    .CONFIRM_CYCLES(CONF),
    .HOLD_CYCLES   (HOLD),
    .TIMEOUT_CYCLES(TMO),
    .CNT_W         (CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .mode         (mode),
    .ballot_enable(ballot_enable),
    .btn          (btn),
    .cand_inc     (cand_inc),
    .vote_casted  (vote_casted),
    .armed        (armed),
    .multi_press  (multi_press),
    .full         (full),
    .ballot_count (ballot_count),
    .timeout      (timeout),
    .state_dbg    (state_dbg)
  );

  // ---------------- scoreboard state ----------------
  logic [3:0] exp_q[$];
  int n_cmp = 0;
  int n_fail = 0;
  int exp_count = 0;
  int cast_total = 0;
  int overlap_cnt = 0;

  // Passive monitor: counts every cand_inc pulse and any overlap with the ack.
  always @(negedge clk) begin
    if (cand_inc != 4'b0000) cast_total++;
    if ((cand_inc != 4'b0000) && vote_casted) overlap_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic arm_pulse;
    ballot_enable = 1'b1;
    tick();
    ballot_enable = 1'b0;
  endtask

  task automatic wait_cast(input int budget, output int lat, output logic [3:0] seen);
    lat  = -1;
    seen = 4'b0000;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (cand_inc !== 4'b0000) begin
        lat  = i;
        seen = cand_inc;
        break;
      end
    end
  endtask

  task automatic finish_ballot;
    btn = 4'b0000;
    ballot_enable = 1'b0;
    repeat (HOLD + 4) tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    #2;
    n_cmp++;
    if ({cand_inc, vote_casted, armed, multi_press, full, timeout} !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b required 0", {cand_inc, vote_casted, armed, multi_press, full, timeout});
    end
    n_cmp++;
    if (ballot_count !== '0) begin
      n_fail++;
      $display("FAIL reset_count: got %0d required 0", ballot_count);
    end
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single_vote;
    int lat;
    int n;
    logic [3:0] seen, exp;
    arm_pulse();
    n_cmp++;
    if (armed !== 1'b1) begin
      n_fail++;
      $display("FAIL single_armed: armed=%b required 1", armed);
    end
    btn = 4'b0010;
    exp_q.push_back(4'b0010);
    wait_cast(20, lat, seen);
    exp = exp_q.pop_front();
    n_cmp++;
    if (seen !== exp) begin
      n_fail++;
      $display("FAIL single_cast: cand_inc=%b required %b", seen, exp);
    end
    n_cmp++;
    if (lat !== CONF + 1) begin
      n_fail++;
      $display("FAIL single_latency: cycles=%0d required %0d", lat, CONF + 1);
    end
    exp_count++;
    tick();
    n_cmp++;
    if ((cand_inc !== 4'b0000) || (vote_casted !== 1'b1)) begin
      n_fail++;
      $display("FAIL ack_follows_cast: cand_inc=%b vote_casted=%b required 0000/1", cand_inc, vote_casted);
    end
    n = 0;
    while (vote_casted === 1'b1 && n < 30) begin
      n++;
      tick();
    end
    n_cmp++;
    if (n !== HOLD) begin
      n_fail++;
      $display("FAIL ack_length: cycles=%0d required %0d", n, HOLD);
    end
    finish_ballot();
    n_cmp++;
    if (ballot_count !== CW'(exp_count)) begin
      n_fail++;
      $display("FAIL single_count: ballot_count=%0d required %0d", ballot_count, exp_count);
    end
  endtask

  task automatic test_multi_press;
    int lat;
    int m;
    int c0;
    logic [3:0] seen, exp;
    arm_pulse();
    c0 = cast_total;
    btn = 4'b0011;
    m = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (multi_press === 1'b1) m++;
    end
    n_cmp++;
    if (m !== 20) begin
      n_fail++;
      $display("FAIL multi_flag: cycles high=%0d required 20", m);
    end
    n_cmp++;
    if ((cast_total !== c0) || (armed !== 1'b1)) begin
      n_fail++;
      $display("FAIL multi_no_cast: casts=%0d armed=%b required %0d/1", cast_total - c0, armed, 0);
    end
    btn = 4'b0000;
    tick();
    n_cmp++;
    if (multi_press !== 1'b0) begin
      n_fail++;
      $display("FAIL multi_clear: multi_press=%b required 0", multi_press);
    end
    btn = 4'b0001;
    exp_q.push_back(4'b0001);
    wait_cast(20, lat, seen);
    exp = exp_q.pop_front();
    n_cmp++;
    if (seen !== exp) begin
      n_fail++;
      $display("FAIL multi_then_single: cand_inc=%b required %b", seen, exp);
    end
    exp_count++;
    finish_ballot();
  endtask

  task automatic test_back_to_back;
    int lat;
    int c0;
    logic [3:0] seen, exp;
    ballot_enable = 1'b1;
    tick();
    btn = 4'b0100;
    c0 = cast_total;
    exp_q.push_back(4'b0100);
    wait_cast(20, lat, seen);
    exp = exp_q.pop_front();
    n_cmp++;
    if (seen !== exp) begin
      n_fail++;
      $display("FAIL held_first_cast: cand_inc=%b required %b", seen, exp);
    end
    exp_count++;
    repeat (40) tick();
    n_cmp++;
    if ((cast_total !== c0 + 1) || (armed !== 1'b0)) begin
      n_fail++;
      $display("FAIL held_single_cast: casts=%0d armed=%b required 1/0", cast_total - c0, armed);
    end
    btn = 4'b0000;
    tick();
    tick();
    n_cmp++;
    if (armed !== 1'b1) begin
      n_fail++;
      $display("FAIL held_rearm: armed=%b required 1", armed);
    end
    btn = 4'b1000;
    exp_q.push_back(4'b1000);
    wait_cast(20, lat, seen);
    exp = exp_q.pop_front();
    n_cmp++;
    if (seen !== exp) begin
      n_fail++;
      $display("FAIL back_to_back_cast: cand_inc=%b required %b", seen, exp);
    end
    exp_count++;
    finish_ballot();
    n_cmp++;
    if (ballot_count !== CW'(exp_count)) begin
      n_fail++;
      $display("FAIL back_to_back_count: ballot_count=%0d required %0d", ballot_count, exp_count);
    end
  endtask

  task automatic test_mode_abort;
    int lat;
    int c0;
    logic [3:0] seen, exp;
    mode = 1'b1;
    ballot_enable = 1'b1;
    repeat (3) tick();
    n_cmp++;
    if (armed !== 1'b0) begin
      n_fail++;
      $display("FAIL display_refuse: armed=%b required 0", armed);
    end
    ballot_enable = 1'b0;
    mode = 1'b0;
    arm_pulse();
    c0 = cast_total;
    btn = 4'b0001;
    tick();
    tick();
    mode = 1'b1;
    repeat (4) tick();
    n_cmp++;
    if ((armed !== 1'b1) || (cast_total !== c0) || (state_dbg !== 3'd1)) begin
      n_fail++;
      $display("FAIL mode_abort: armed=%b casts=%0d state=%0d required 1/0/1", armed, cast_total - c0, state_dbg);
    end
    mode = 1'b0;
    exp_q.push_back(4'b0001);
    wait_cast(20, lat, seen);
    exp = exp_q.pop_front();
    n_cmp++;
    if ((seen !== exp) || (lat !== CONF + 1)) begin
      n_fail++;
      $display("FAIL mode_recover: cand_inc=%b lat=%0d required %b/%0d", seen, lat, exp, CONF + 1);
    end
    exp_count++;
    finish_ballot();
    n_cmp++;
    if (cast_total !== c0 + 1) begin
      n_fail++;
      $display("FAIL mode_single: casts=%0d required 1", cast_total - c0);
    end
  endtask

  task automatic test_timeout;
    int n;
    int bad;
    int lat;
    logic [3:0] seen, exp;
`ifdef VOTE_TIMEOUT_EN
    arm_pulse();
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (timeout === 1'b1) begin
        n = i;
        break;
      end
    end
    n_cmp++;
    if ((n !== TMO) || (armed !== 1'b0)) begin
      n_fail++;
      $display("FAIL timeout_pulse: at cycle %0d armed=%b required %0d/0", n, armed, TMO);
    end
    tick();
    n_cmp++;
    if (timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_width: timeout=%b required 0", timeout);
    end
    bad = 0;
    lat = 0;
    seen = 4'b0000;
    exp = 4'b0000;
`else
    arm_pulse();
    bad = 0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if ((timeout !== 1'b0) || (armed !== 1'b1)) bad++;
    end
    n_cmp++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL no_timeout: bad cycles=%0d required 0", bad);
    end
    btn = 4'b0010;
    exp_q.push_back(4'b0010);
    wait_cast(20, lat, seen);
    exp = exp_q.pop_front();
    n_cmp++;
    if (seen !== exp) begin
      n_fail++;
      $display("FAIL late_cast: cand_inc=%b required %b", seen, exp);
    end
    exp_count++;
    finish_ballot();
`endif
  endtask

  task automatic test_full;
    int lat;
    int c0;
    int cand;
    int a;
    logic [3:0] seen, exp;
    while (exp_count < 255) begin
      cand = $urandom_range(0, 3);
      arm_pulse();
      btn = 4'b0001 << cand;
      exp_q.push_back(4'b0001 << cand);
      wait_cast(20, lat, seen);
      exp = exp_q.pop_front();
      n_cmp++;
      if (seen !== exp) begin
        n_fail++;
        $display("FAIL fill_cast %0d: cand_inc=%b required %b", exp_count, seen, exp);
      end
      exp_count++;
      repeat ($urandom_range(0, 3)) tick();
      finish_ballot();
    end
    n_cmp++;
    if ((ballot_count !== 8'hFF) || (full !== 1'b1)) begin
      n_fail++;
      $display("FAIL full_flag: ballot_count=%0d full=%b required 255/1", ballot_count, full);
    end
    c0 = cast_total;
    a = 0;
    ballot_enable = 1'b1;
    btn = 4'b0100;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (armed !== 1'b0) a++;
    end
    ballot_enable = 1'b0;
    btn = 4'b0000;
    tick();
    n_cmp++;
    if ((a !== 0) || (cast_total !== c0) || (ballot_count !== 8'hFF)) begin
      n_fail++;
      $display("FAIL full_refuse: armed cycles=%0d casts=%0d count=%0d required 0/0/255", a, cast_total - c0, ballot_count);
    end
  endtask

  task automatic test_reset_mid;
    int lat;
    int c0;
    logic [3:0] seen, exp;
    rst = 1'b0;
    #1;
    n_cmp++;
    if ((ballot_count !== '0) || (full !== 1'b0)) begin
      n_fail++;
      $display("FAIL reset_clears_count: count=%0d full=%b required 0/0", ballot_count, full);
    end
    rst = 1'b1;
    exp_count = 0;
    tick();
    arm_pulse();
    btn = 4'b0010;
    tick();
    tick();
    #2;
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({cand_inc, vote_casted, armed, multi_press, timeout} !== 8'b0) begin
      n_fail++;
      $display("FAIL reset_mid_confirm: outputs=%b required 0", {cand_inc, vote_casted, armed, multi_press, timeout});
    end
    rst = 1'b1;
    c0 = cast_total;
    repeat (10) tick();
    n_cmp++;
    if ((cast_total !== c0) || (armed !== 1'b0)) begin
      n_fail++;
      $display("FAIL reset_no_resume: casts=%0d armed=%b required 0/0", cast_total - c0, armed);
    end
    btn = 4'b0000;
    tick();
    arm_pulse();
    btn = 4'b0001;
    exp_q.push_back(4'b0001);
    wait_cast(20, lat, seen);
    exp = exp_q.pop_front();
    n_cmp++;
    if (seen !== exp) begin
      n_fail++;
      $display("FAIL reset_pre_cast: cand_inc=%b required %b", seen, exp);
    end
    #1;
    rst = 1'b0;
    #1;
    n_cmp++;
    if ((cand_inc !== 4'b0000) || (ballot_count !== '0)) begin
      n_fail++;
      $display("FAIL reset_mid_cast: cand_inc=%b count=%0d required 0000/0", cand_inc, ballot_count);
    end
    rst = 1'b1;
    btn = 4'b0000;
    repeat (3) tick();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_single_vote();
    test_multi_press();
    test_back_to_back();
    test_mode_abort();
    test_timeout();
    test_full();
    test_reset_mid();
    n_cmp++;
    if (overlap_cnt !== 0) begin
      n_fail++;
      $display("FAIL overlap: cand_inc with vote_casted cycles=%0d required 0", overlap_cnt);
    end
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: pending=%0d required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
